// File: rtl/ddr2_rd_fifo_ctrl_0.sv
// ddr2_rd_fifo_ctrl_0: tracks issued DDR2 read bursts and drains the rise/fall
// data FIFO pair one burst at a time once enough words have landed.
// Optional read watchdog: define DDR2_RD_TIMEOUT_EN.
module ddr2_rd_fifo_ctrl_0 #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_cmd,
  input  logic       rd_cmd_bl8,
  output logic       rd_cmd_ready,
  input  logic       read_en_delayed_rise,
  input  logic       read_en_delayed_fall,
  output logic       fifo_rd_en,
  output logic       rd_busy,
  output logic [3:0] outstanding,
  output logic       ovf_err,
  output logic       udf_err,
  output logic       skew_err,
  output logic       timeout_err
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned SLOTS = 1 << PTR_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OCC_W = 5;
  localparam int unsigned DL_W  = 2;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_DRAIN     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SLOTS-1:0]  bl8_q, bl8_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DL_W-1:0]   drain_left_q, drain_left_d;
  logic              fifo_rd_en_q, fifo_rd_en_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, skew_q, skew_d;
  logic              rst_sync_q;
  logic              push, pop;
  logic [PTR_W-1:0]  rd_ptr_inc, wr_ptr_inc;
  logic [OCC_W-1:0]  head_words, next_words;
`ifdef DDR2_RD_TIMEOUT_EN
  logic [7:0]        wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_cmd_ready = (cnt_q < CNT_MAX);
  assign rd_busy      = (state_q != ST_IDLE) || (cnt_q != '0);
  assign outstanding  = cnt_q;
  assign fifo_rd_en   = fifo_rd_en_q;
  assign ovf_err      = ovf_q;
  assign udf_err      = udf_q;
  assign skew_err     = skew_q;
`ifdef DDR2_RD_TIMEOUT_EN
  assign timeout_err  = timeout_q;
`else
  assign timeout_err  = 1'b0;
`endif

  assign push       = rd_cmd && rd_cmd_ready;
  assign rd_ptr_inc = ptr_inc(rd_ptr_q);
  assign wr_ptr_inc = ptr_inc(wr_ptr_q);
  assign head_words = bl8_q[rd_ptr_q]   ? OCC_W'(4) : OCC_W'(2);
  assign next_words = bl8_q[rd_ptr_inc] ? OCC_W'(4) : OCC_W'(2);

  // Reset assertion is immediate; release is re-timed to clk by one stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 1'b0;
    else          rst_sync_q <= 1'b1;
  end

  // Next-state: occupancy/error tracking, burst sequencing, command queue.
  always_comb begin
    state_d      = state_q;
    bl8_d        = bl8_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    occ_d        = occ_q;
    drain_left_d = drain_left_q;
    fifo_rd_en_d = 1'b0;
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    skew_d       = skew_q;
    pop          = 1'b0;
`ifdef DDR2_RD_TIMEOUT_EN
    wdog_d       = '0;
    timeout_d    = timeout_q;
`endif

    if (read_en_delayed_rise && !fifo_rd_en_q) begin
      if (occ_q >= OCC_FULL) ovf_d = 1'b1;
      else                   occ_d = occ_q + OCC_W'(1);
    end else if (fifo_rd_en_q && !read_en_delayed_rise) begin
      if (occ_q == '0) udf_d = 1'b1;
      else             occ_d = occ_q - OCC_W'(1);
    end
    if (read_en_delayed_rise != read_en_delayed_fall) skew_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (occ_d >= head_words) begin
          state_d      = ST_DRAIN;
          fifo_rd_en_d = 1'b1;
          drain_left_d = DL_W'(head_words - OCC_W'(1));
        end
`ifdef DDR2_RD_TIMEOUT_EN
        else if (wdog_q == 8'hFF) begin
          timeout_d = 1'b1;
          pop       = 1'b1;
          state_d   = ((cnt_q > CNT_W'(1)) || push) ? ST_WAIT_DATA : ST_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      ST_DRAIN: begin
        if (drain_left_q != '0) begin
          fifo_rd_en_d = 1'b1;
          drain_left_d = drain_left_q - DL_W'(1);
        end else begin
          // Last word: retire head and chain straight into the next burst if its data is in.
          pop = 1'b1;
          if (cnt_q > CNT_W'(1)) begin
            if (occ_d >= next_words) begin
              state_d      = ST_DRAIN;
              fifo_rd_en_d = 1'b1;
              drain_left_d = DL_W'(next_words - OCC_W'(1));
            end else begin
              state_d = ST_WAIT_DATA;
            end
          end else if (push) begin
            state_d = ST_WAIT_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      bl8_d[wr_ptr_q] = rd_cmd_bl8;
      wr_ptr_d        = wr_ptr_inc;
    end
    if (pop) rd_ptr_d = rd_ptr_inc;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State register; held in reset until the synchronised release lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bl8_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      occ_q        <= '0;
      drain_left_q <= '0;
      fifo_rd_en_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      skew_q       <= 1'b0;
`ifdef DDR2_RD_TIMEOUT_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else if (!rst_sync_q) begin
      state_q      <= ST_IDLE;
      bl8_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      occ_q        <= '0;
      drain_left_q <= '0;
      fifo_rd_en_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      skew_q       <= 1'b0;
`ifdef DDR2_RD_TIMEOUT_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bl8_q        <= bl8_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
      drain_left_q <= drain_left_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      skew_q       <= skew_d;
`ifdef DDR2_RD_TIMEOUT_EN
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr2_rd_fifo_ctrl_0.sv
// Testbench for ddr2_rd_fifo_ctrl_0: directed timing checks plus a randomized
// scoreboard run against a burst/word-level reference model.
module tb_ddr2_rd_fifo_ctrl_0;

  localparam int MAXO  = 4;
  localparam int DEPTH = 16;

  logic       clk, reset_n, rd_cmd, rd_cmd_bl8, rise, fall;
  logic       rd_cmd_ready, fifo_rd_en, rd_busy, ovf_err, udf_err, skew_err, timeout_err;
  logic [3:0] outstanding;

  typedef struct {
    int id;
    int idx;
    int words;
  } word_t;

  word_t exp_q[$];
  int    n_vec, n_err;
  int    model_out, model_occ, pending, next_id, n_pulses;
  bit    m_ovf, m_udf, m_skew, cmd_acc, prev_en, mon_en;

  ddr2_rd_fifo_ctrl_0 #(.MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .rd_cmd               (rd_cmd),
    .rd_cmd_bl8           (rd_cmd_bl8),
    .rd_cmd_ready         (rd_cmd_ready),
    .read_en_delayed_rise (rise),
    .read_en_delayed_fall (fall),
    .fifo_rd_en           (fifo_rd_en),
    .rd_busy              (rd_busy),
    .outstanding          (outstanding),
    .ovf_err              (ovf_err),
    .udf_err              (udf_err),
    .skew_err             (skew_err),
    .timeout_err          (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs with the model, pops scoreboard on each drain word.
  always @(negedge clk) begin : mon
    int    last;
    word_t w;
    if (!reset_n) begin
      model_out = 0; model_occ = 0; m_ovf = 0; m_udf = 0; m_skew = 0; prev_en = 0;
      exp_q.delete();
    end else if (mon_en) begin
      last = 0;
      check("outstanding", int'(outstanding), model_out);
      check("rd_cmd_ready", int'(rd_cmd_ready), int'(model_out < MAXO));
      check("rd_busy", int'(rd_busy), int'(model_out != 0));
      check("ovf_err", int'(ovf_err), int'(m_ovf));
      check("udf_err", int'(udf_err), int'(m_udf));
      check("skew_err", int'(skew_err), int'(m_skew));
      check("timeout_err", int'(timeout_err), 0);
      if (fifo_rd_en) begin
        n_pulses++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_en_unexpected: fifo_rd_en=1, expected 0 (no word pending, t=%0t)", $time);
        end else begin
          w = exp_q.pop_front();
          if (w.idx == 0 && model_occ < w.words) begin
            n_err++;
            $display("FAIL drain_early: burst %0d started with %0d words buffered, expected >= %0d", w.id, model_occ, w.words);
          end else if (w.idx != 0 && !prev_en) begin
            n_err++;
            $display("FAIL drain_gap: burst %0d word %0d after idle cycle, expected consecutive", w.id, w.idx);
          end
          if (w.idx == w.words - 1) last = 1;
        end
      end
      model_out = model_out + int'(cmd_acc) - last;
      if (rise && !fifo_rd_en) begin
        if (model_occ >= DEPTH) m_ovf = 1;
        else model_occ++;
      end else if (fifo_rd_en && !rise) begin
        if (model_occ == 0) m_udf = 1;
        else model_occ--;
      end
      if (rise != fall) m_skew = 1;
      prev_en = fifo_rd_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; accepted commands push their words to the scoreboard.
  task automatic drive(input bit cmd, input bit bl8, input bit r, input bit f);
    int w;
    rd_cmd = cmd; rd_cmd_bl8 = bl8; rise = r; fall = f;
    cmd_acc = cmd && (model_out < MAXO);
    if (cmd_acc) begin
      w = bl8 ? 4 : 2;
      for (int i = 0; i < w; i++) exp_q.push_back('{next_id, i, w});
      next_id++;
      pending += w;
    end
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rd_cmd = 1'b0; rise = 1'b0; fall = 1'b0; cmd_acc = 1'b0; pending = 0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((model_out != 0 || exp_q.size() != 0) && n < budget) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL drain_timeout: %0d bursts outstanding after %0d cycles, expected 0", model_out, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int n0, k;
    bit c, b, d;
    n_vec = 0; n_err = 0; n_pulses = 0; next_id = 0; pending = 0;
    reset_n = 1'b0; rd_cmd = 1'b0; rd_cmd_bl8 = 1'b0; rise = 1'b0; fall = 1'b0;
    cmd_acc = 1'b0; mon_en = 1'b0;

    // Reset values while reset_n is low.
    #3;
    check("rst_outstanding", int'(outstanding), 0);
    check("rst_ready", int'(rd_cmd_ready), 1);
    check("rst_busy", int'(rd_busy), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_errs", int'({ovf_err, udf_err, skew_err, timeout_err}), 0);

    // Release: command in first cycle ignored, second accepted; then single BL4 timing.
    step();
    reset_n = 1'b1; rd_cmd = 1'b1; rd_cmd_bl8 = 1'b0;
    step();
    check("cmd_during_sync_ignored", int'(outstanding), 0);
    step();
    rd_cmd = 1'b0;
    check("bl4_outstanding_1", int'(outstanding), 1);
    check("bl4_busy", int'(rd_busy), 1);
    repeat (4) step();
    rise = 1'b1; fall = 1'b1;
    step();
    check("bl4_no_rd_en_before_data", int'(fifo_rd_en), 0);
    step();
    rise = 1'b0; fall = 1'b0;
    check("bl4_rd_en_word0", int'(fifo_rd_en), 1);
    step();
    check("bl4_rd_en_word1", int'(fifo_rd_en), 1);
    check("bl4_outstanding_mid", int'(outstanding), 1);
    step();
    check("bl4_rd_en_done", int'(fifo_rd_en), 0);
    check("bl4_outstanding_0", int'(outstanding), 0);
    check("bl4_busy_done", int'(rd_busy), 0);

    // Four back-to-back BL8, fifth rejected, 16 streamed words drained without gaps.
    do_reset();
    mon_en = 1'b1;
    n0 = n_pulses;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("ready_low_after_4", int'(rd_cmd_ready), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("outstanding_after_5th", int'(outstanding), 4);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    wait_drained(50);
    check("bl8x4_pulses", n_pulses - n0, 16);

    // Randomized traffic against the scoreboard.
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      c = ($urandom_range(0, 2) == 0);
      b = 1'($urandom_range(0, 1));
      d = (pending > 0) && ($urandom_range(0, 2) != 0);
      if (d) pending--;
      drive(c, b, d, d);
    end
    k = 0;
    while (pending > 0 && k < 40) begin
      pending--;
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      k++;
    end
    wait_drained(100);

    // Overflow saturation at FIFO_DEPTH, then skew.
    do_reset();
    n0 = n_pulses;
    for (int i = 0; i < 17; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_after_17", int'(ovf_err), 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    wait_drained(60);
    check("ovf_saturated_drain", n_pulses - n0, 16);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("skew_set", int'(skew_err), 1);

    // Reset during drain word 2 of 4.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    k = 0;
    while (!fifo_rd_en && k < 10) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    check("mid_drain_word1", int'(fifo_rd_en), 1);
    step();
    check("mid_drain_word2", int'(fifo_rd_en), 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("abort_rd_en", int'(fifo_rd_en), 0);
    check("abort_outstanding", int'(outstanding), 0);
    check("abort_ready", int'(rd_cmd_ready), 1);
    check("abort_busy", int'(rd_busy), 0);
    check("abort_errs", int'({ovf_err, udf_err, skew_err, timeout_err}), 0);
    step();
    check("abort_rd_en_held", int'(fifo_rd_en), 0);

    // Waiting for data that never arrives.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (300) drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DDR2_RD_TIMEOUT_EN
    check("wd_timeout_err", int'(timeout_err), 1);
    check("wd_outstanding", int'(outstanding), 0);
    check("wd_busy", int'(rd_busy), 0);
`else
    check("wd_timeout_err", int'(timeout_err), 0);
    check("wd_outstanding", int'(outstanding), 1);
    check("wd_busy", int'(rd_busy), 1);
`endif
    check("wd_rd_en", int'(fifo_rd_en), 0);
    reset_n = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr2_rd_fifo_ctrl_0.md
DDR2_RD_FIFO_CTRL_0 -- requirements
Module: ddr2_rd_fifo_ctrl_0

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, meaning read bursts tracked at once (2..8).
REQ-002 Parameter FIFO_DEPTH, default 16, meaning capacity of the rise/fall data FIFO pair in words.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rd_cmd  input  1  one-cycle pulse, read burst issued to memory.
REQ-006 rd_cmd_bl8  input  1  burst length of rd_cmd: 1 = BL8 (4 words), 0 = BL4 (2 words).
REQ-007 rd_cmd_ready  output  1  high when a new rd_cmd is accepted.
REQ-008 read_en_delayed_rise  input  1  rise-FIFO write strobe, one word per cycle high.
REQ-009 read_en_delayed_fall  input  1  fall-FIFO write strobe, one word per cycle high.
REQ-010 fifo_rd_en  output  1  read strobe to the data FIFO pair, one word per cycle high.
REQ-011 rd_busy  output  1  high when any burst is outstanding or draining.
REQ-012 outstanding  output  4  bursts accepted but not fully drained.
REQ-013 ovf_err, udf_err, skew_err  output  1 each  sticky error flags.

Function
REQ-014 Command queue: MAX_OUTSTANDING-entry FIFO of burst-length bits; push on rd_cmd while rd_cmd_ready; rd_cmd while not ready ignored.
REQ-015 rd_cmd_ready = outstanding < MAX_OUTSTANDING, combinational from registered count.
REQ-016 Occupancy counter, 5 bits: +1 on read_en_delayed_rise, -1 on fifo_rd_en, unchanged when both.
REQ-017 States IDLE, WAIT_DATA, DRAIN; reset to IDLE.
REQ-018 IDLE -> WAIT_DATA when queue non-empty; WAIT_DATA -> DRAIN when occupancy >= words of head entry (2 or 4).
REQ-019 DRAIN: fifo_rd_en high for exactly head-entry word count on consecutive cycles, first at cycle after entry.
REQ-020 On last drain word: pop head, decrement outstanding; next state WAIT_DATA if queue still non-empty, else IDLE (no idle gap required).
REQ-021 rd_cmd and last drain word in same cycle: outstanding unchanged, both entries handled correctly.
REQ-022 Occupancy reaching FIFO_DEPTH with further rise strobe: set ovf_err, saturate count.
REQ-023 fifo_rd_en with occupancy 0 never occurs; if condition arises, set udf_err and hold count at 0.
REQ-024 read_en_delayed_rise != read_en_delayed_fall in any cycle: set skew_err.
REQ-025 Error flags sticky until reset; they do not stop the state machine.
REQ-026 rd_busy = (state != IDLE) or (outstanding != 0).

Reset
REQ-027 Async assertion of reset_n low immediately forces: state IDLE, queue empty, occupancy 0, outstanding 0, fifo_rd_en 0, rd_busy 0, rd_cmd_ready 1, all error flags 0.
REQ-028 Reset mid-DRAIN aborts the burst; no fifo_rd_en after reset_n falls.
REQ-029 Release of reset_n is synchronised to clk; first command accepted on second clk edge after release.

Configuration
REQ-030 Macro DDR2_RD_TIMEOUT_EN defined: 8-bit watchdog counts cycles in WAIT_DATA, clears on exit; at 255 sets output timeout_err (sticky), pops head entry, decrements outstanding, returns to IDLE/WAIT_DATA per REQ-020.
REQ-031 Macro undefined: no watchdog; timeout_err port present, tied 0; WAIT_DATA waits indefinitely.

Verification
REQ-032 Single BL4: rd_cmd bl8=0, 2 rise+fall strobes 5 cycles later -> fifo_rd_en high 2 cycles starting cycle after 2nd strobe; outstanding 1->0.
REQ-033 Four back-to-back BL8 cmds, 16 data words streamed -> rd_cmd_ready 0 after 4th cmd; 16 fifo_rd_en pulses, no gaps between bursts; final outstanding 0.
REQ-034 Fifth rd_cmd while outstanding=4 -> ignored, outstanding stays 4, no extra drain.
REQ-035 17 rise strobes with no cmd -> ovf_err 1, occupancy 16; rise strobe without fall strobe -> skew_err 1.
REQ-036 reset_n low during DRAIN word 2 of 4 -> fifo_rd_en 0 same cycle, all outputs at reset values.
REQ-037 DDR2_RD_TIMEOUT_EN defined, BL4 cmd, no data for 255 cycles -> timeout_err 1, outstanding 0, state IDLE.
